rr_arbiter: RTL and testbench

Round-robin arbiter that grants one of `REQ_W` requesters at a time and produces a registered one-hot grant vector. It is the stage directly upstream of `onehot_dec`: its `grant` output is guaranteed zero-or-one-hot, so it can be fed straight into the decoder to obtain the winner index. Each grant is held until the winner acknowledges it, and priority rotates past the last winner.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/onehot_dec.sv | 19 +
 rtl/rr_arbiter.sv | 83 ++++++++
 tb/tb_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbitration types and the round-robin winner pick, reusable by any
// arbiter up to ARB_MAX_W requesters.
package arb_pkg;

  // Two-state handshake: IDLE arbitrates, BUSY holds the grant until ack.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Widest request vector rr_pick can handle; narrower callers zero-extend.
  localparam int unsigned ARB_MAX_W = 32;

  // Returns the one-hot winner: the lowest request at or above ptr, or the
  // lowest request overall when nothing sits at or above ptr.
  function automatic logic [ARB_MAX_W-1:0] rr_pick(
    input logic [ARB_MAX_W-1:0] req,
    input int unsigned          ptr
  );
    logic [ARB_MAX_W-1:0] masked;
    logic [ARB_MAX_W-1:0] src;
    masked = req & ~((ARB_MAX_W'(1) << ptr) - ARB_MAX_W'(1));
    src    = (masked != '0) ? masked : req;
    // Two's-complement trick isolates the lowest set bit.
    return src & (~src + ARB_MAX_W'(1));
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// One-hot (or all-zero) vector to binary index. An all-zero input yields 0.
module onehot_dec #(
  parameter int VECTOR_W = 4,
  parameter int IDX_W    = $clog2(VECTOR_W)
) (
  input  logic [VECTOR_W-1:0] onehot,
  output logic [IDX_W-1:0]    index
);

  // OR together the positions of the set bits; exact for one-hot inputs.
  always_comb begin
    // NOTE: default assignment first so no path leaves index unassigned (no latch).
    index = '0;
    for (int i = 0; i < VECTOR_W; i++) begin
      if (onehot[i]) index = index | IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held until the
// winner acknowledges it. Priority rotates to just past the last winner.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int REQ_W = 4,
  parameter int IDX_W = $clog2(REQ_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req,
  input  logic             ack,
  output logic [REQ_W-1:0] grant,
  output logic             grant_valid
);

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     ptr_next;
  logic [ARB_MAX_W-1:0] pick_full;
  logic [REQ_W-1:0]     winner;

  // Combinational winner for the current request vector and pointer.
  assign pick_full = rr_pick(ARB_MAX_W'(req), 32'(ptr));
  assign winner    = pick_full[REQ_W-1:0];

  generate
    if (REQ_W < ARB_MAX_W) begin : g_pick_hi
      // Upper bits are always zero because req is zero-extended.
      logic unused_pick_hi;
      assign unused_pick_hi = ^pick_full[ARB_MAX_W-1:REQ_W];
    end
  endgenerate

  // Winner index comes from the held grant, so ptr follows the actual winner.
  onehot_dec #(
    .VECTOR_W (REQ_W),
    .IDX_W    (IDX_W)
  ) u_grant_dec (
    .onehot (grant),
    .index  (grant_idx)
  );

  // Explicit wrap so non-power-of-two REQ_W never lands on an unused index.
  assign ptr_next = (grant_idx == IDX_W'(REQ_W - 1)) ? '0 : grant_idx + IDX_W'(1);

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= winner;
            grant_valid <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // Requests are ignored here; only ack releases the grant.
          if (ack) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= ptr_next;
            state       <= IDLE;
          end
        end
        default: begin
          grant       <= '0;
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (REQ_W=4): directed scenarios plus a
// randomized run, all compared against a rotating-scan reference model.
module tb_rr_arbiter;

  localparam int REQ_W = 4;

  logic             clk;
  logic             rst_n;
  logic [REQ_W-1:0] req;
  logic             ack;
  logic [REQ_W-1:0] grant;
  logic             grant_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: priority start, busy flag, current winner.
  int m_ptr  = 0;
  bit m_busy = 0;
  int m_win  = 0;

  rr_arbiter #(.REQ_W(REQ_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] exp_grant();
    return m_busy ? REQ_W'(1 << m_win) : '0;
  endfunction

  // Model: scan requesters starting at m_ptr, wrapping around, first one wins.
  task automatic model_edge(input logic [REQ_W-1:0] r, input logic a);
    if (!m_busy) begin
      for (int k = 0; k < REQ_W; k++) begin
        int j;
        j = (m_ptr + k) % REQ_W;
        if (r[j]) begin
          m_win  = j;
          m_busy = 1;
          break;
        end
      end
    end else if (a) begin
      m_ptr  = (m_win + 1) % REQ_W;
      m_busy = 0;
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = 0;
    m_win  = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle #1.
  task automatic tick(input logic [REQ_W-1:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    model_edge(r, a);
    #1;
  endtask

  // Invariants checked every cycle away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (!$onehot0(grant)) begin
        n_err++;
        $display("FAIL onehot0: grant=%b", grant);
      end
      n_cmp++;
      if (grant_valid !== (|grant)) begin
        n_err++;
        $display("FAIL valid_eq_or: grant_valid=%b grant=%b", grant_valid, grant);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    #12;
    n_cmp++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: grant=%b valid=%b want 0000/0", grant, grant_valid);
    end
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000, 1'b0);
      n_cmp++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset[%0d]: grant=%b valid=%b want 0000/0", i, grant, grant_valid);
      end
    end
  endtask

  task automatic test_single_hold();
    tick(4'b0100, 1'b0);
    n_cmp++;
    if (grant !== 4'b0100 || grant_valid !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: grant=%b valid=%b want 0100/1", grant, grant_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick(4'b0100, 1'b0);
      n_cmp++;
      if (grant !== 4'b0100) begin
        n_err++;
        $display("FAIL single_hold[%0d]: grant=%b want 0100", i, grant);
      end
    end
    tick(4'b0100, 1'b1);
    n_cmp++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_release: grant=%b valid=%b want 0000/0", grant, grant_valid);
    end
    // Bit 3 now has top priority over bit 0.
    tick(4'b1001, 1'b0);
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_err++;
      $display("FAIL single_next_prio: grant=%b want 1000", grant);
    end
    tick(4'b0000, 1'b1);
  endtask

  task automatic test_rotation();
    logic [REQ_W-1:0] seq [10];
    seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
            4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      tick(4'b1111, 1'b1);
      n_cmp++;
      if (grant !== seq[i]) begin
        n_err++;
        $display("FAIL rotation[%0d]: grant=%b want %b", i, grant, seq[i]);
      end
    end
  endtask

  task automatic test_wrap();
    // Leaves ptr at 1 from rotation; grant/ack bit 2 to move ptr to 3.
    tick(4'b0100, 1'b0);
    tick(4'b0000, 1'b1);
    tick(4'b0011, 1'b0);
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL wrap_ptr3: grant=%b want 0001", grant);
    end
    tick(4'b0000, 1'b1);
    tick(4'b1000, 1'b0);
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_err++;
      $display("FAIL wrap_bit3: grant=%b want 1000", grant);
    end
    tick(4'b0000, 1'b1);
    tick(4'b1001, 1'b0);
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL wrap_to0: grant=%b want 0001", grant);
    end
    tick(4'b0000, 1'b1);
  endtask

  task automatic test_ignored_ack_drop();
    // ptr is 1 here; idle acks must not move it.
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, 1'b1);
      n_cmp++;
      if (grant !== 4'b0000) begin
        n_err++;
        $display("FAIL idle_ack[%0d]: grant=%b want 0000", i, grant);
      end
    end
    tick(4'b0011, 1'b0);
    n_cmp++;
    if (grant !== 4'b0010) begin
      n_err++;
      $display("FAIL idle_ack_ptr: grant=%b want 0010", grant);
    end
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, 1'b0);
      n_cmp++;
      if (grant !== 4'b0010) begin
        n_err++;
        $display("FAIL drop_req_hold[%0d]: grant=%b want 0010", i, grant);
      end
    end
    tick(4'b0000, 1'b1);
    n_cmp++;
    if (grant !== 4'b0000) begin
      n_err++;
      $display("FAIL drop_req_release: grant=%b want 0000", grant);
    end
  endtask

  task automatic test_async_reset();
    tick(4'b1000, 1'b0);
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_err++;
      $display("FAIL areset_setup: grant=%b want 1000", grant);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL areset_immediate: grant=%b valid=%b want 0000/0", grant, grant_valid);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    tick(4'b1001, 1'b0);
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL areset_ptr0: grant=%b want 0001", grant);
    end
    tick(4'b0000, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(REQ_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if (grant !== exp_grant() || grant_valid !== m_busy) begin
        n_err++;
        $display("FAIL random[%0d]: grant=%b valid=%b want %b/%b",
                 i, grant, grant_valid, exp_grant(), m_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_rotation();
    test_wrap();
    test_ignored_ack_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
